// File: rtl/musb_shift_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : musb_shift_issue_pkg
// Description : Shared types for the shift issue stage: op-code encoding,
//               operand-stage entry layout and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package musb_shift_issue_pkg;

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;

  typedef enum logic [2:0] {
    SHOP_SLL  = 3'd0,
    SHOP_SRL  = 3'd1,
    SHOP_SRA  = 3'd2,
    SHOP_SLLV = 3'd3,
    SHOP_SRLV = 3'd4,
    SHOP_SRAV = 3'd5,
    SHOP_RSV6 = 3'd6,
    SHOP_RSV7 = 3'd7
  } shop_e;

  // Operand-stage contents (destination register kept separately because
  // its width is a module parameter).
  typedef struct packed {
    shop_e              op;
    logic [DATA_W-1:0]  rt;
    logic [AMT_W-1:0]   rs_amt;
    logic [AMT_W-1:0]   shamt;
  } s1_entry_t;

  // Variable shifts take the amount from rs[4:0].
  function automatic logic is_var_shift(input shop_e op);
    return (op == SHOP_SLLV) || (op == SHOP_SRLV) || (op == SHOP_SRAV);
  endfunction

  function automatic logic is_reserved(input shop_e op);
    return (op == SHOP_RSV6) || (op == SHOP_RSV7);
  endfunction

endpackage
`default_nettype wire

// File: rtl/musb_shift_issue_if.sv
`default_nettype none
// ============================================================================
// Module      : musb_shift_issue_if
// Description : Issue-side and writeback-side valid/ready bus of the shift
//               issue stage. slave = the stage, master = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface musb_shift_issue_if #(
  parameter int REG_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [31:0]       in_rt_data;
  logic [31:0]       in_rs_data;
  logic [4:0]        in_shamt;
  logic [REG_W-1:0]  in_rd;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [REG_W-1:0]  out_rd;
  logic              out_wb_en;
  logic              out_illegal;

  modport slave (
    input  in_valid, in_op, in_rt_data, in_rs_data, in_shamt, in_rd, out_ready,
    output in_ready, out_valid, out_data, out_rd, out_wb_en, out_illegal
  );

  modport master (
    output in_valid, in_op, in_rt_data, in_rs_data, in_shamt, in_rd, out_ready,
    input  in_ready, out_valid, out_data, out_rd, out_wb_en, out_illegal
  );
endinterface
`default_nettype wire

// File: rtl/musb_shift_issue.sv
`default_nettype none
// ============================================================================
// Module      : musb_shift_issue
// Description : EX-side issue stage for MIPS32 shifts. S1 holds the operand
//               and drives the external combinational shifter; S2 registers
//               the result toward writeback. One op per cycle, with flush.
// Revision    : 1.0 - initial release
// ============================================================================
module musb_shift_issue
  import musb_shift_issue_pkg::*;
#(
  parameter int REG_W     = 5,
  parameter bit ILL_CHECK = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  musb_shift_issue_if.slave    bus,
  output logic [DATA_W-1:0]    sh_input_data,
  output logic [AMT_W-1:0]     sh_shamnt,
  output logic                 sh_direction,
  output logic                 sh_sign_extend,
  input  logic [DATA_W-1:0]    sh_result
);

  // Operand stage
  logic              s1_valid_q, s1_valid_d;
  s1_entry_t         s1_q, s1_d;
  logic [REG_W-1:0]  s1_rd_q, s1_rd_d;

  // Result stage
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;
  logic [REG_W-1:0]  s2_rd_q, s2_rd_d;
  logic              s2_wb_q, s2_wb_d;
  logic              s2_ill_q, s2_ill_d;

  logic w_s2_free;
  logic w_in_fire;
  logic w_s1_adv;
  logic w_s1_ill;
  logic w_unused_rs;

  // Only the low five bits of rs carry a shift amount.
  assign w_unused_rs = ^bus.in_rs_data[31:AMT_W];

  assign w_s2_free    = !s2_valid_q || bus.out_ready;
  assign bus.in_ready = !s1_valid_q || w_s2_free;
  assign w_in_fire    = bus.in_valid && bus.in_ready;
  assign w_s1_adv     = s1_valid_q && w_s2_free;

  generate
    if (ILL_CHECK) begin : g_ill_chk
      assign w_s1_ill = is_reserved(s1_q.op);
    end else begin : g_ill_none
      assign w_s1_ill = 1'b0;
    end
  endgenerate

  // Operand stage next state: flush beats load, load beats drain.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s1_rd_d    = s1_rd_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (w_in_fire) begin
      s1_valid_d    = 1'b1;
      s1_d.op       = shop_e'(bus.in_op);
      s1_d.rt       = bus.in_rt_data;
      s1_d.rs_amt   = bus.in_rs_data[AMT_W-1:0];
      s1_d.shamt    = bus.in_shamt;
      s1_rd_d       = bus.in_rd;
    end else if (w_s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Shifter drive decoded from S1; reserved codes decode as SLL and are
  // quiet when S1 is empty.
  always_comb begin
    sh_input_data  = '0;
    sh_shamnt      = '0;
    sh_direction   = 1'b0;
    sh_sign_extend = 1'b0;
    if (s1_valid_q) begin
      sh_input_data = s1_q.rt;
      sh_shamnt     = is_var_shift(s1_q.op) ? s1_q.rs_amt : s1_q.shamt;
      unique case (s1_q.op)
        SHOP_SLL, SHOP_SLLV, SHOP_RSV6, SHOP_RSV7: sh_direction   = 1'b1;
        SHOP_SRA, SHOP_SRAV:                       sh_sign_extend = 1'b1;
        default: ;
      endcase
    end
  end

  // Result stage next state: capture on advance, drop on downstream accept.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_rd_d    = s2_rd_q;
    s2_wb_d    = s2_wb_q;
    s2_ill_d   = s2_ill_q;
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (w_s1_adv) begin
      s2_valid_d = 1'b1;
      s2_data_d  = w_s1_ill ? '0 : sh_result;
      s2_rd_d    = s1_rd_q;
      s2_ill_d   = w_s1_ill;
      s2_wb_d    = !w_s1_ill && (s1_rd_q != '0);
    end else if (bus.out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // Pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s1_rd_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_rd_q    <= '0;
      s2_wb_q    <= 1'b0;
      s2_ill_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s1_rd_q    <= s1_rd_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_rd_q    <= s2_rd_d;
      s2_wb_q    <= s2_wb_d;
      s2_ill_q   <= s2_ill_d;
    end
  end

  assign bus.out_valid   = s2_valid_q;
  assign bus.out_data    = s2_data_q;
  assign bus.out_rd      = s2_rd_q;
  assign bus.out_wb_en   = s2_wb_q;
  assign bus.out_illegal = s2_ill_q;

endmodule
`default_nettype wire

// File: tb/tb_musb_shift_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_musb_shift_issue
// Description : Self-checking bench for musb_shift_issue with an in-bench
//               shifter and a queue-based reference of in-flight ops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_musb_shift_issue;

  localparam int REG_W = 5;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] sh_input_data;
  logic [4:0]  sh_shamnt;
  logic        sh_direction;
  logic        sh_sign_extend;
  logic [31:0] sh_result;

  musb_shift_issue_if #(.REG_W(REG_W)) bus ();

  musb_shift_issue #(.REG_W(REG_W), .ILL_CHECK(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .bus            (bus),
    .sh_input_data  (sh_input_data),
    .sh_shamnt      (sh_shamnt),
    .sh_direction   (sh_direction),
    .sh_sign_extend (sh_sign_extend),
    .sh_result      (sh_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational shifter seen by the stage.
  always_comb begin
    if (sh_direction)        sh_result = sh_input_data << sh_shamnt;
    else if (sh_sign_extend) sh_result = $unsigned($signed(sh_input_data) >>> sh_shamnt);
    else                     sh_result = sh_input_data >> sh_shamnt;
  end

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        ill;
    logic        wb;
    bit          fresh;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   last_in_fire;
  bit   prev_stall;
  logic [31:0] prev_data;
  logic [4:0]  prev_rd;
  logic        prev_wb, prev_ill;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Architectural meaning of each shift op.
  function automatic exp_t ref_op(input logic [2:0] op, input logic [31:0] rt,
                                  input logic [31:0] rs, input logic [4:0] shamt,
                                  input logic [4:0] rd);
    exp_t e;
    int   amt;
    amt = (op >= 3 && op <= 5) ? int'(rs[4:0]) : int'(shamt);
    e.ill = (op >= 6);
    case (op)
      3'd0, 3'd3: e.data = rt << amt;
      3'd1, 3'd4: e.data = rt >> amt;
      3'd2, 3'd5: e.data = $unsigned($signed(rt) >>> amt);
      default:    e.data = 32'd0;
    endcase
    e.rd    = rd;
    e.wb    = !e.ill && (rd != 5'd0);
    e.fresh = 1'b1;
    return e;
  endfunction

  // One clock: check at negedge, advance the reference at posedge.
  task automatic tick();
    bit   exp_ready, exp_ov, in_fire, out_fire;
    exp_t ne;
    @(negedge clk);
    exp_ready = !(q.size() >= 2 && !bus.out_ready);
    exp_ov    = (q.size() > 0) && !q[0].fresh;
    check_val("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
    check_val("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
    if (exp_ov && bus.out_valid) begin
      check_val("out_data", bus.out_data, q[0].data);
      check_val("out_rd", {27'd0, bus.out_rd}, {27'd0, q[0].rd});
      check_val("out_wb_en", {31'd0, bus.out_wb_en}, {31'd0, q[0].wb});
      check_val("out_illegal", {31'd0, bus.out_illegal}, {31'd0, q[0].ill});
    end
    if (prev_stall) begin
      check_val("stall_data", bus.out_data, prev_data);
      check_val("stall_rd", {27'd0, bus.out_rd}, {27'd0, prev_rd});
    end
    in_fire  = bus.in_valid && exp_ready;
    out_fire = exp_ov && bus.out_ready;
    ne = ref_op(bus.in_op, bus.in_rt_data, bus.in_rs_data, bus.in_shamt, bus.in_rd);
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
    prev_rd    = bus.out_rd;
    prev_wb    = bus.out_wb_en;
    prev_ill   = bus.out_illegal;
    @(posedge clk);
    last_in_fire = 1'b0;
    if (!rst || flush) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (out_fire) void'(q.pop_front());
      foreach (q[i]) q[i].fresh = 1'b0;
      if (in_fire) begin
        q.push_back(ne);
        last_in_fire = 1'b1;
      end
    end
    #1;
  endtask

  task automatic set_op(input logic [2:0] op, input logic [31:0] rt, input logic [31:0] rs,
                        input logic [4:0] shamt, input logic [4:0] rd);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_rt_data = rt;
    bus.in_rs_data = rs;
    bus.in_shamt   = shamt;
    bus.in_rd      = rd;
  endtask

  // Present an op until accepted, bounded.
  task automatic issue(input logic [2:0] op, input logic [31:0] rt, input logic [31:0] rs,
                       input logic [4:0] shamt, input logic [4:0] rd);
    int budget;
    set_op(op, rt, rs, shamt, rd);
    budget = 0;
    do begin
      tick();
      budget++;
    end while (!last_in_fire && budget < 20);
    if (!last_in_fire) check_val("issue_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    bus.out_ready = 1'b1;
    set_op(3'd0, 32'h1, 32'h0, 5'd3, 5'd7);
    prev_stall = 1'b0;
    @(posedge clk); #1;

    // Reset held with an op offered: nothing captured, outputs zero.
    tick(); tick();
    check_val("rst_out_data", bus.out_data, 32'd0);
    check_val("rst_out_rd", {27'd0, bus.out_rd}, 32'd0);
    check_val("rst_out_wb", {31'd0, bus.out_wb_en}, 32'd0);
    check_val("rst_out_ill", {31'd0, bus.out_illegal}, 32'd0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();

    // Directed ops: latency, variable shifts, illegal and $zero.
    issue(3'd0, 32'h0000_0001, 32'h0, 5'd31, 5'd8);
    tick(); tick();
    issue(3'd5, 32'h8000_00F0, 32'hFFFF_FFE4, 5'd0, 5'd3);
    issue(3'd4, 32'h8000_00F0, 32'hFFFF_FFE4, 5'd0, 5'd4);
    issue(3'd6, 32'h1234_5678, 32'h0, 5'd2, 5'd5);
    issue(3'd0, 32'h0000_0003, 32'h0, 5'd1, 5'd0);
    repeat (3) tick();

    // Stream of 8 ops with out_ready toggling every cycle.
    for (int i = 0; i < 8; i++) begin
      int budget;
      set_op(3'(i % 6), $urandom, $urandom, 5'($urandom), 5'(i + 1));
      budget = 0;
      do begin
        tick();
        bus.out_ready = !bus.out_ready;
        budget++;
      end while (!last_in_fire && budget < 20);
      if (!last_in_fire) check_val("stream_timeout", 32'd0, 32'd1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();

    // Flush with both stages full and an op offered.
    bus.out_ready = 1'b0;
    issue(3'd1, 32'hF000_0000, 32'h0, 5'd4, 5'd9);
    issue(3'd2, 32'hF000_0000, 32'h0, 5'd4, 5'd10);
    set_op(3'd0, 32'h5, 32'h0, 5'd1, 5'd11);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    issue(3'd3, 32'h0000_000F, 32'h0000_0004, 5'd0, 5'd12);
    repeat (3) tick();

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.in_op      = 3'($urandom);
      bus.in_rt_data = $urandom;
      bus.in_rs_data = $urandom;
      bus.in_shamt   = 5'($urandom);
      bus.in_rd      = 5'($urandom);
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 39) == 0);
      rst            = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    check_val("drained", {31'd0, bus.out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
